// File: rtl/vecmac_pkg.sv
// vecmac_pkg: shared widths and types for the vector MAC datapath.
// Both the beat source and the accumulator derive their widths here.
package vecmac_pkg;

    // Width of one lane product (int8 x int8, signed).
    localparam int INW_BASE = 16;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_FIN
    } vbs_state_e;

    // Extra sum bits needed to reduce LANES products without overflow.
    function automatic int stages_for(input int lanes);
        return (lanes < 4) ? 2 : $clog2(lanes);
    endfunction

    function automatic int psum_width(input int lanes, input int inw_base);
        return inw_base + stages_for(lanes);
    endfunction

endpackage

// File: rtl/lane_adder_tree.sv
// lane_adder_tree: reduces LANES signed products into one partial sum.
// The sum is registered once; a valid bit travels with it.
module lane_adder_tree
    import vecmac_pkg::*;
#(
    parameter int LANES = 4,
    parameter int W_OUT = psum_width(LANES, INW_BASE)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    input  logic [INW_BASE*LANES-1:0] lanes,
    output logic                      out_valid,
    output logic [W_OUT-1:0]          sum
);

    logic signed [W_OUT-1:0]    sum_d;
    logic signed [INW_BASE-1:0] term;

    // Sign-extend every lane product and add them up exactly.
    always_comb begin
        sum_d = '0;
        term  = '0;
        for (int i = 0; i < LANES; i++) begin
            term  = lanes[INW_BASE*i +: INW_BASE];
            sum_d = sum_d + W_OUT'(term);
        end
    end

    // Output register for the reduced sum and its valid flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            sum       <= '0;
        end else begin
            out_valid <= in_valid;
            sum       <= sum_d;
        end
    end

endmodule

// File: rtl/vec_beat_source.sv
// vec_beat_source: walks two int8 vectors in memory and emits one
// dot-product partial sum per beat, followed by a done pulse.
module vec_beat_source
    import vecmac_pkg::*;
#(
    parameter int LANES  = 4,
    parameter int ELEMS  = 1000,
    parameter int ADDR_W = 10,
    localparam int BEATS = (ELEMS + LANES - 1) / LANES,
    localparam int W_OUT = psum_width(LANES, INW_BASE)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic                 mem_en,
    output logic [ADDR_W-1:0]    mem_addr,
    input  logic [8*LANES-1:0]   a_rdata,
    input  logic [8*LANES-1:0]   b_rdata,
    output logic                 busy,
    output logic [W_OUT-1:0]     partial_sum,
    output logic                 out_valid,
    output logic                 done
);

    // Number of live lanes in the final beat.
    localparam int TAIL = ELEMS - (BEATS - 1) * LANES;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(BEATS - 1);

    vbs_state_e state_q, state_d;
    logic [ADDR_W-1:0] addr_q;

    logic rd_valid, rd_last;
    logic p_valid;
    logic [INW_BASE*LANES-1:0] prod_d, prod_q;

    logic signed [7:0]          a_l, b_l;
    logic signed [INW_BASE-1:0] prd;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next state: drain ends once only the last beat remains in flight.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start) state_d = S_FETCH;
            S_FETCH: if (addr_q == LAST_ADDR) state_d = S_DRAIN;
            S_DRAIN: if (out_valid && !p_valid && !rd_valid)
                         state_d = S_FIN;
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Decoded outputs.
    always_comb begin
        mem_en = (state_q == S_FETCH);
        busy   = (state_q != S_IDLE);
        done   = (state_q == S_FIN);
    end

    // Address counter: zeroed on accept, stops on the last beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
        end else if (state_q == S_IDLE && start) begin
            addr_q <= '0;
        end else if (state_q == S_FETCH && addr_q != LAST_ADDR) begin
            addr_q <= addr_q + ADDR_W'(1);
        end
    end

    assign mem_addr = addr_q;

    // Track which cycles carry read data and whether it is the tail beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
        end else begin
            rd_valid <= mem_en;
            rd_last  <= mem_en && (addr_q == LAST_ADDR);
        end
    end

    // Lane products, with unused tail lanes forced to zero.
    always_comb begin
        prod_d = '0;
        a_l    = '0;
        b_l    = '0;
        prd    = '0;
        for (int i = 0; i < LANES; i++) begin
            a_l = a_rdata[8*i +: 8];
            b_l = b_rdata[8*i +: 8];
            prd = INW_BASE'(a_l) * INW_BASE'(b_l);
            if (rd_last && (i >= TAIL)) prd = '0;
            prod_d[INW_BASE*i +: INW_BASE] = prd;
        end
    end

    // Product register stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_valid <= 1'b0;
            prod_q  <= '0;
        end else begin
            p_valid <= rd_valid;
            prod_q  <= prod_d;
        end
    end

    lane_adder_tree #(
        .LANES (LANES),
        .W_OUT (W_OUT)
    ) u_tree (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (p_valid),
        .lanes     (prod_q),
        .out_valid (out_valid),
        .sum       (partial_sum)
    );

endmodule

// File: tb/tb_vec_beat_source.sv
// tb_vec_beat_source: several configurations run side by side against
// an element-level dot-product model.
module tb_vec_beat_source;

    localparam int NI = 6;
    localparam logic [NI-1:0][7:0] LNP =
        {8'd8, 8'd2, 8'd1, 8'd4, 8'd16, 8'd4};
    localparam logic [NI-1:0][7:0] ELP =
        {8'd21, 8'd11, 8'd13, 8'd4, 8'd16, 8'd10};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;

    always #5 clk = ~clk;

    logic       men  [NI];
    logic       bsy  [NI];
    logic       ov   [NI];
    logic       dn   [NI];
    logic [9:0] maddr[NI];
    int         ps   [NI];

    logic [7:0]        amem[NI][64][16];
    logic [7:0]        bmem[NI][64][16];
    logic signed [7:0] va[NI][64];
    logic signed [7:0] vb[NI][64];

    for (genvar g = 0; g < NI; g++) begin : gi
        localparam int L = int'(LNP[g]);
        localparam int E = int'(ELP[g]);
        localparam int W = 16 + ((L < 4) ? 2 : $clog2(L));
        logic [8*L-1:0] a_rd, b_rd;
        logic [W-1:0]   psr;
        logic [9:0]     ad;
        logic           me, bu, v, d;

        always @(posedge clk) begin
            if (me) begin
                for (int i = 0; i < L; i++) begin
                    a_rd[8*i +: 8] <= amem[g][ad[5:0]][i];
                    b_rd[8*i +: 8] <= bmem[g][ad[5:0]][i];
                end
            end
        end

        vec_beat_source #(
            .LANES  (L),
            .ELEMS  (E),
            .ADDR_W (10)
        ) u_dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .start       (start),
            .mem_en      (me),
            .mem_addr    (ad),
            .a_rdata     (a_rd),
            .b_rdata     (b_rd),
            .busy        (bu),
            .partial_sum (psr),
            .out_valid   (v),
            .done        (d)
        );

        assign men[g]   = me;
        assign bsy[g]   = bu;
        assign ov[g]    = v;
        assign dn[g]    = d;
        assign maddr[g] = ad;
        assign ps[g]    = int'(signed'(psr));
    end

    int total = 0;
    int bad = 0;

    int   got  [NI][$];
    int   first[NI];
    int   last [NI];
    int   ndone[NI];
    int   dcyc [NI];
    logic blog [NI][64];

    task automatic chk(input string tag, input int g,
                       input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s[%0d] observed=%0d expected=%0d",
                   tag, g, obs, exp);
        end
    endtask

    function automatic int exp_beat(input int g, input int k);
        int l, e, s;
        l = int'(LNP[g]);
        s = 0;
        for (int i = 0; i < l; i++) begin
            e = k * l + i;
            if (e < int'(ELP[g]))
                s += int'(va[g][e]) * int'(vb[g][e]);
        end
        return s;
    endfunction

    task automatic fill(input int g, input int mode);
        int l, el, e;
        l  = int'(LNP[g]);
        el = int'(ELP[g]);
        for (int i = 0; i < 64; i++) begin
            case (mode)
                0: begin va[g][i] = 8'sd1; vb[g][i] = 8'sd1; end
                1: begin va[g][i] = -8'sd128; vb[g][i] = -8'sd128; end
                2: begin va[g][i] = -8'sd128; vb[g][i] = 8'sd127; end
                default: begin
                    va[g][i] = 8'($urandom);
                    vb[g][i] = 8'($urandom);
                end
            endcase
        end
        for (int w = 0; w < 64; w++) begin
            for (int i = 0; i < 16; i++) begin
                e = w * l + i;
                if (i < l && e < el) begin
                    amem[g][w][i] = va[g][e];
                    bmem[g][w][i] = vb[g][e];
                end else if (mode == 0) begin
                    amem[g][w][i] = 8'h7F;
                    bmem[g][w][i] = 8'h7F;
                end else begin
                    amem[g][w][i] = 8'($urandom);
                    bmem[g][w][i] = 8'($urandom);
                end
            end
        end
    endtask

    task automatic clear_logs();
        for (int g = 0; g < NI; g++) begin
            got[g].delete();
            first[g] = -1;
            last[g]  = -1;
            ndone[g] = 0;
            dcyc[g]  = -1;
            for (int c = 0; c < 64; c++) blog[g][c] = 1'b0;
        end
    endtask

    task automatic capture(input int n, input int restart_at);
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            for (int g = 0; g < NI; g++) begin
                if (ov[g]) begin
                    got[g].push_back(ps[g]);
                    if (first[g] < 0) first[g] = c;
                    last[g] = c;
                end
                if (dn[g]) begin
                    ndone[g]++;
                    dcyc[g] = c;
                end
                if (c < 64) blog[g][c] = bsy[g];
            end
            start = (c == restart_at);
        end
    endtask

    task automatic check_reset(input string tag);
        int x;
        for (int g = 0; g < NI; g++) begin
            x = (men[g] || bsy[g] || ov[g] || dn[g]) ? 1 : 0;
            chk({tag, "_ctl"}, g, x, 0);
            chk({tag, "_psum"}, g, ps[g], 0);
            chk({tag, "_addr"}, g, int'(maddr[g]), 0);
        end
    endtask

    task automatic check_run(input int g);
        int b;
        b = (int'(ELP[g]) + int'(LNP[g]) - 1) / int'(LNP[g]);
        chk("nbeats", g, got[g].size(), b);
        for (int k = 0; k < b && k < got[g].size(); k++)
            chk("beat", g, got[g][k], exp_beat(g, k));
        chk("first_valid", g, first[g], 4);
        chk("last_valid", g, last[g], b + 3);
        chk("done_cnt", g, ndone[g], 1);
        chk("done_cyc", g, dcyc[g], b + 4);
        chk("busy_start", g, int'(blog[g][1]), 1);
        chk("busy_done", g, int'(blog[g][b + 4]), 1);
        chk("busy_after", g, int'(blog[g][b + 5]), 0);
        chk("addr_hold", g, int'(maddr[g]), b - 1);
    endtask

    initial begin
        fill(0, 0);
        fill(1, 1);
        fill(2, 2);
        fill(3, 3);
        fill(4, 3);
        fill(5, 3);
        clear_logs();

        repeat (3) @(posedge clk);
        #1;
        check_reset("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Run 1, with a second start pulse that must be ignored.
        @(negedge clk);
        start = 1'b1;
        clear_logs();
        capture(30, 2);
        for (int g = 0; g < NI; g++) check_run(g);
        chk("tail_b0", 0, got[0][0], 4);
        chk("tail_b1", 0, got[0][1], 4);
        chk("tail_b2", 0, got[0][2], 2);
        chk("neg_sq", 1, got[1][0], 262144);
        chk("mixed", 2, got[2][0], -65024);

        // Run 2 with fresh random vectors.
        fill(3, 3);
        fill(4, 3);
        fill(5, 3);
        @(negedge clk);
        start = 1'b1;
        clear_logs();
        capture(30, -1);
        for (int g = 0; g < NI; g++) check_run(g);

        // Reset after the second beat of the 3-beat run.
        @(negedge clk);
        start = 1'b1;
        clear_logs();
        capture(5, -1);
        chk("pre_rst_beats", 0, got[0].size(), 2);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1 check_reset("mid_rst");
        @(posedge clk);
        #1 rst_n = 1'b1;
        clear_logs();
        capture(20, -1);
        for (int g = 0; g < NI; g++) begin
            chk("post_rst_beats", g, got[g].size(), 0);
            chk("post_rst_done", g, ndone[g], 0);
        end

        // A fresh start after reset reproduces a full run.
        @(negedge clk);
        start = 1'b1;
        clear_logs();
        capture(30, -1);
        for (int g = 0; g < NI; g++) check_run(g);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
